ntt_frame_reorder_buffer: RTL and testbench

- Parametrised ping-pong frame buffer between an AXI-Stream coefficient source and the NTT/INTT core.
- Collects N-word frames on the slave port into one of two banks, and drains full banks on the master port.
- Drain order is natural or bit-reversed, selected per frame.
- One bank fills while the other drains. Frame-length errors are flagged, and completed frames are counted.

---
 rtl/ntt_frame_reorder_buffer.sv | 157 +++++++++++++++
 tb/tb_ntt_frame_reorder_buffer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_frame_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : ntt_frame_reorder_buffer
// Ping-pong N-word frame buffer feeding the NTT/INTT core, with natural or
// bit-reversed drain order chosen per frame.
// Revision : 1.0
// ============================================================================
module ntt_frame_reorder_buffer #(
  parameter int DATA_W = 32,
  parameter int LOG2N  = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  input  logic              ntt_intt_sel,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [CNT_W-1:0]  frame_count,
  output logic              frame_err
);

  localparam int               c_N        = 2**LOG2N;
  localparam logic [LOG2N-1:0] c_LAST_IDX = '1;

  logic [DATA_W-1:0] r_mem [2][c_N];

  logic [1:0]        r_full;
  logic [1:0]        r_mode;
  logic              r_wr_bank;
  logic [LOG2N-1:0]  r_wr_idx;
  logic              r_rd_bank;
  logic              r_ld_bank;
  logic [LOG2N-1:0]  r_ld_idx;
  logic              r_valid;
  logic              r_last;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_count;
  logic              r_err;

  logic              w_wr_hs;
  logic              w_wr_end;
  logic              w_wr_abort;
  logic              w_rd_hs;
  logic              w_rd_end;
  logic              w_load;
  logic [LOG2N-1:0]  w_ld_addr;

  function automatic logic [LOG2N-1:0] f_bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = v[LOG2N-1-i];
    end
    return r;
  endfunction

  assign s_axis_tready = !r_full[r_wr_bank];
  assign w_wr_hs       = s_axis_tvalid && s_axis_tready;
  assign w_wr_end      = w_wr_hs && (r_wr_idx == c_LAST_IDX);
  assign w_wr_abort    = w_wr_hs && s_axis_tlast && (r_wr_idx != c_LAST_IDX);

  assign w_rd_hs   = r_valid && m_axis_tready;
  assign w_rd_end  = w_rd_hs && r_last;
  // The loader runs one word ahead of the output register, so it moves on to
  // the other bank as soon as the last word is staged; this removes the bubble.
  assign w_load    = r_full[r_ld_bank] && (!r_valid || m_axis_tready);
  assign w_ld_addr = r_mode[r_ld_bank] ? f_bitrev(r_ld_idx) : r_ld_idx;

  assign m_axis_tdata  = r_data;
  assign m_axis_tvalid = r_valid;
  assign m_axis_tlast  = r_last;
  assign frame_count   = r_count;
  assign frame_err     = r_err;

  always_ff @(posedge clk) begin
    if (w_wr_hs) begin
      r_mem[r_wr_bank][r_wr_idx] <= s_axis_tdata;
    end
  end

  // Each bank's full flag is set only by the writer and cleared only by the
  // reader; the two can never target the same bank in one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full <= 2'b00;
      r_mode <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_wr_end && (r_wr_bank == 1'(i))) begin
          r_full[i] <= 1'b1;
        end else if (w_rd_end && (r_rd_bank == 1'(i))) begin
          r_full[i] <= 1'b0;
        end
        if (w_wr_hs && (r_wr_idx == '0) && (r_wr_bank == 1'(i))) begin
          r_mode[i] <= ntt_intt_sel;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_bank <= 1'b0;
      r_wr_idx  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_wr_abort || (w_wr_end && !s_axis_tlast);
      if (w_wr_end) begin
        r_wr_bank <= ~r_wr_bank;
        r_wr_idx  <= '0;
      end else if (w_wr_abort) begin
        r_wr_idx  <= '0;
      end else if (w_wr_hs) begin
        r_wr_idx  <= r_wr_idx + LOG2N'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ld_bank <= 1'b0;
      r_ld_idx  <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_data    <= '0;
    end else if (w_load) begin
      r_valid  <= 1'b1;
      r_last   <= (r_ld_idx == c_LAST_IDX);
      r_data   <= r_mem[r_ld_bank][w_ld_addr];
      r_ld_idx <= r_ld_idx + LOG2N'(1);
      if (r_ld_idx == c_LAST_IDX) begin
        r_ld_bank <= ~r_ld_bank;
      end
    end else if (w_rd_hs) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_bank <= 1'b0;
      r_count   <= '0;
    end else if (w_rd_end) begin
      r_rd_bank <= ~r_rd_bank;
      r_count   <= r_count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ntt_frame_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntt_frame_reorder_buffer
// Scoreboard bench: expected output frames are queued from a reference model.
// Revision : 1.0
// ============================================================================
module tb_ntt_frame_reorder_buffer;

  localparam int DATA_W = 32;
  localparam int LOG2N  = 8;
  localparam int CNT_W  = 8;
  localparam int N      = 2**LOG2N;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] s_axis_tdata = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic              s_axis_tlast = 1'b0;
  logic              ntt_intt_sel = 1'b0;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic              m_axis_tlast;
  logic [CNT_W-1:0]  frame_count;
  logic              frame_err;

  always #5 clk = ~clk;

  ntt_frame_reorder_buffer #(
    .DATA_W(DATA_W), .LOG2N(LOG2N), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .ntt_intt_sel(ntt_intt_sel),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .frame_count(frame_count), .frame_err(frame_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int err_cnt  = 0;
  int out_cnt  = 0;
  int cyc      = 0;
  bit sink_hold   = 1'b0;
  bit sink_rand   = 1'b0;
  bit src_rand    = 1'b0;
  bit stall_watch = 1'b0;
  bit saw_stall   = 1'b0;

  logic [DATA_W-1:0] q_data [$];
  logic              q_last [$];
  logic [DATA_W-1:0] fbuf [N];

  logic              p_valid = 1'b0;
  logic              p_ready = 1'b0;
  logic              p_last  = 1'b0;
  logic [DATA_W-1:0] p_data  = '0;
  logic [DATA_W-1:0] exp_d;
  logic              exp_l;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Bit reversal by repeated halving, independent of any hardware form.
  function automatic int ref_rev(input int j);
    int r = 0;
    int v = j;
    for (int b = 0; b < LOG2N; b++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  // Drives nwords words; the model queues a frame only if all N were accepted.
  task automatic send_frame(input int nwords, input int tlast_at, input bit sel,
                            input bit rand_data, input logic [DATA_W-1:0] base,
                            input int flip_at);
    int k = 0;
    int guard = 0;
    bit mode_l = 1'b0;
    logic [DATA_W-1:0] cur;
    cur = rand_data ? $urandom : base;
    while (k < nwords) begin
      @(posedge clk); #1;
      s_axis_tvalid = src_rand ? (((cyc / 4) % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b1;
      s_axis_tdata  = cur;
      s_axis_tlast  = (k == tlast_at);
      ntt_intt_sel  = (flip_at >= 0 && k >= flip_at) ? !sel : sel;
      @(negedge clk);
      if (stall_watch && !s_axis_tready) saw_stall = 1'b1;
      if (s_axis_tvalid && s_axis_tready) begin
        if (k == 0) mode_l = sel;
        fbuf[k] = cur;
        k++;
        guard = 0;
        cur = rand_data ? $urandom : base + DATA_W'(k);
        if (k == N) begin
          for (int j = 0; j < N; j++) begin
            q_data.push_back(fbuf[mode_l ? ref_rev(j) : j]);
            q_last.push_back(j == N - 1);
          end
        end
      end else begin
        guard++;
        if (guard > 3000) begin
          chk("src_timeout", 64'(guard), 64'd0);
          break;
        end
      end
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input int exp_fc, input int exp_err, input int exp_out);
    int g = 0;
    @(negedge clk);
    while ((q_data.size() != 0 || m_axis_tvalid) && g < 8000) begin
      @(negedge clk);
      g++;
    end
    chk("drain_done", 64'(q_data.size() == 0 && !m_axis_tvalid), 64'd1);
    repeat (3) @(negedge clk);
    chk("frame_count", 64'(frame_count), 64'(exp_fc));
    chk("frame_err_pulses", 64'(err_cnt), 64'(exp_err));
    chk("words_out", 64'(out_cnt), 64'(exp_out));
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    reset = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (2) @(posedge clk);
    q_data.delete();
    q_last.delete();
    #3;
    reset   = 1'b0;
    err_cnt = 0;
    out_cnt = 0;
  endtask

  // Monitor: pops the scoreboard on each output handshake and checks AXI holds.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        p_valid = 1'b0;
      end else begin
        if (frame_err) err_cnt++;
        if (p_valid && !p_ready) begin
          chk("hold_valid", 64'(m_axis_tvalid), 64'd1);
          chk("hold_data", 64'(m_axis_tdata), 64'(p_data));
          chk("hold_last", 64'(m_axis_tlast), 64'(p_last));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          out_cnt++;
          chk("word_expected", 64'(q_data.size() > 0), 64'd1);
          if (q_data.size() > 0) begin
            exp_d = q_data.pop_front();
            exp_l = q_last.pop_front();
            chk("out_data", 64'(m_axis_tdata), 64'(exp_d));
            chk("out_last", 64'(m_axis_tlast), 64'(exp_l));
          end
        end
        p_valid = m_axis_tvalid;
        p_ready = m_axis_tready;
        p_data  = m_axis_tdata;
        p_last  = m_axis_tlast;
      end
    end
  end

  // Sink
  initial begin
    forever begin
      @(posedge clk); #1;
      if (sink_hold) m_axis_tready = 1'b0;
      else if (sink_rand) m_axis_tready = ((cyc / 4) % 2 == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      else m_axis_tready = 1'b1;
    end
  end

  initial begin
    int g;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    @(negedge clk);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("rst_count", 64'(frame_count), 64'd0);
    chk("rst_err", 64'(frame_err), 64'd0);
    chk("rst_tready", 64'(s_axis_tready), 64'd1);

    // Natural-order frame 0..255
    send_frame(N, N - 1, 1'b0, 1'b0, 32'd0, -1);
    wait_drain(1, 0, N);

    // Bit-reversed frame; sel flips at word 100 and must be ignored
    do_reset();
    send_frame(N, N - 1, 1'b1, 1'b0, 32'd0, 100);
    wait_drain(1, 0, N);

    // Three random frames with throttling; both banks fill while sink is held
    do_reset();
    src_rand = 1'b1;
    sink_rand = 1'b1;
    sink_hold = 1'b1;
    stall_watch = 1'b1;
    saw_stall = 1'b0;
    fork
      begin
        send_frame(N, N - 1, 1'b0, 1'b1, 32'd0, -1);
        send_frame(N, N - 1, 1'b1, 1'b1, 32'd0, -1);
        send_frame(N, N - 1, 1'b0, 1'b1, 32'd0, -1);
      end
      begin
        repeat (1200) @(posedge clk);
        sink_hold = 1'b0;
      end
    join
    wait_drain(3, 0, 3 * N);
    chk("tready_stall_seen", 64'(saw_stall), 64'd1);
    stall_watch = 1'b0;

    // Early tlast on word 99, then a clean frame
    do_reset();
    send_frame(100, 99, 1'b0, 1'b0, 32'd0, -1);
    send_frame(N, N - 1, 1'b0, 1'b0, 32'd1000, -1);
    wait_drain(1, 1, N);

    // Missing tlast on word 255: flagged but kept
    do_reset();
    send_frame(N, -1, 1'b1, 1'b1, 32'd0, -1);
    wait_drain(1, 1, N);

    // Reset in the middle of a drain
    do_reset();
    src_rand = 1'b0;
    sink_rand = 1'b0;
    send_frame(N, N - 1, 1'b0, 1'b1, 32'd0, -1);
    g = 0;
    while (out_cnt < 50 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("reached_word50", 64'(out_cnt >= 50), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("midrst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("midrst_count", 64'(frame_count), 64'd0);
    q_data.delete();
    q_last.delete();
    @(posedge clk); #3;
    reset = 1'b0;
    out_cnt = 0;
    err_cnt = 0;
    @(negedge clk);
    chk("midrst_tready", 64'(s_axis_tready), 64'd1);
    chk("midrst_tvalid_after", 64'(m_axis_tvalid), 64'd0);
    send_frame(N, N - 1, 1'b1, 1'b1, 32'd0, -1);
    wait_drain(1, 0, N);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
